// File: rtl/proxy_pkg.sv
// proxy_pkg: shared definitions for the proxy stream feeder.
//   state_e       : feeder FSM state (PASS / PROXY / FLUSH)
//   STALL_CNT_W   : width of the optional stall-cycle counter
//   STALL_CNT_MAX : saturation value of that counter
package proxy_pkg;

    typedef enum logic [1:0] {
        PASS  = 2'd0,
        PROXY = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam int STALL_CNT_W = 16;
    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

endpackage

// File: rtl/proxy_stream_feeder_if.sv
// proxy_stream_feeder_if: upstream word handshake into the feeder.
//   in_valid : word offered by the producer
//   in_ready : feeder can take a word this cycle
//   in_data  : the offered word (WORD_SIZE bits)
// master = producer side, slave = feeder side.
interface proxy_stream_feeder_if #(
    parameter int WORD_SIZE = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WORD_SIZE-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/proxy_fifo.sv
// proxy_fifo: input word buffer of the feeder. FIFO_DEPTH must be a power
// of two (pointers wrap naturally) and at least 2.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : write wdata_i (taken when not full, or when full and popping)
//   pop_i      : drop the head word (ignored while empty)
//   clear_i    : synchronous clear; a push in the same cycle is dropped
//   rdata_o    : head word (valid while not empty)
//   full_o, empty_o, count_o : occupancy status
module proxy_fifo #(
    parameter int WORD_SIZE  = 16,
    parameter int FIFO_DEPTH = 4,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int CW = AW + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic                 clear_i,
    input  logic [WORD_SIZE-1:0] wdata_i,
    output logic [WORD_SIZE-1:0] rdata_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [CW-1:0]        count_o
);

    logic [WORD_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 pop_ok;
    logic                 push_ok;

    assign full_o  = (count_q == CW'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A full buffer still takes a word when the head leaves in the same cycle.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & ~clear_i & (~full_o | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only read while count_q says valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/proxy_stream_feeder.sv
// proxy_stream_feeder: buffers upstream words and feeds them into a downstream
// vDFF row. In PASS the vDFF is transparent-registered (1-cycle latency); in
// PROXY its shift path adds a stall stage (2-cycle latency). FLUSH is a single
// bubble cycle that pushes the stalled word out to Q before shift_en drops.
// A shadow copy of the vDFF validity (tag_stalled_q, q_valid_q) drives q_valid.
//
// Optional feature macro: PROXY_STATS_EN adds stall_cnt, a saturating count of
// cycles with shift_en high (cleared only by reset).
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   up         : upstream word handshake (slave side)
//   fault_en   : request proxy mode
//   flush      : synchronous buffer clear
//   out_data   : vDFF D input (0 on bubbles)
//   shift_en   : vDFF shift enable
//   q_valid    : vDFF Q holds a real word this cycle
//   busy       : buffer non-empty or not in PASS
//   stall_cnt  : (PROXY_STATS_EN only) shift_en cycle counter
//
// state | meaning
// PASS  | vDFF transparent, words pop straight through
// PROXY | vDFF shifting through its stall stage, words still pop
// FLUSH | one bubble cycle draining the stall stage, no pop
module proxy_stream_feeder
    import proxy_pkg::*;
#(
    parameter int WORD_SIZE  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    proxy_stream_feeder_if.slave   up,
    input  logic                   fault_en,
    input  logic                   flush,
    output logic [WORD_SIZE-1:0]   out_data,
    output logic                   shift_en,
    output logic                   q_valid,
    output logic                   busy
`ifdef PROXY_STATS_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e               state_q, state_d;
    logic                 tag_stalled_q, tag_stalled_d;
    logic                 q_valid_q, q_valid_d;
    logic                 pop;
    logic                 cur_valid;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;
    logic [WORD_SIZE-1:0] fifo_head;

    proxy_fifo #(
        .WORD_SIZE (WORD_SIZE),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (up.in_valid),
        .pop_i  (pop),
        .clear_i(flush),
        .wdata_i(up.in_data),
        .rdata_o(fifo_head),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .count_o(fifo_count)
    );

    // pop does not depend on in_valid, so there is no ready/valid loop.
    assign up.in_ready = ~fifo_full | pop;
    assign q_valid     = q_valid_q;
    assign busy        = (fifo_count != '0) || (state_q != PASS);

    always_comb begin
        state_d       = state_q;
        shift_en      = (state_q != PASS);
        pop           = 1'b0;
        cur_valid     = 1'b0;
        out_data      = '0;
        q_valid_d     = q_valid_q;
        tag_stalled_d = tag_stalled_q;

        if (flush) begin
            state_d = (state_q == PASS) ? PASS : FLUSH;
        end else begin
            case (state_q)
                PASS:    if (fault_en)  state_d = PROXY;
                PROXY:   if (!fault_en) state_d = FLUSH;
                FLUSH:   state_d = fault_en ? PROXY : PASS;
                default: state_d = PASS;
            endcase
        end

        // A word popped on a flush edge would escape the clear, so flush
        // also blocks the pop.
        pop       = (state_q != FLUSH) && !fifo_empty && !flush;
        cur_valid = pop;
        if (pop) out_data = fifo_head;

        if (shift_en) begin
            q_valid_d     = tag_stalled_q;
            tag_stalled_d = cur_valid;
        end else begin
            q_valid_d     = cur_valid;
            tag_stalled_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= PASS;
            tag_stalled_q <= 1'b0;
            q_valid_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            tag_stalled_q <= tag_stalled_d;
            q_valid_q     <= q_valid_d;
        end
    end

`ifdef PROXY_STATS_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (shift_en && (stall_cnt_q != STALL_CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_proxy_stream_feeder.sv
module tb_proxy_stream_feeder;
    import proxy_pkg::*;

    localparam int W     = 16;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         fault_en;
    logic         flush;
    logic [W-1:0] out_data;
    logic         shift_en;
    logic         q_valid;
    logic         busy;
`ifdef PROXY_STATS_EN
    logic [STALL_CNT_W-1:0] stall_cnt;
`endif

    proxy_stream_feeder_if #(.WORD_SIZE(W)) up();

    proxy_stream_feeder #(.WORD_SIZE(W), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .up       (up),
        .fault_en (fault_en),
        .flush    (flush),
        .out_data (out_data),
        .shift_en (shift_en),
        .q_valid  (q_valid),
        .busy     (busy)
`ifdef PROXY_STATS_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Reference model: mode 0=pass-through, 1=proxy, 2=flush bubble.
    int           mode;
    logic [W-1:0] mq[$];
    bit           m_st, m_qv;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    bit           cur_v, cur_f, cur_fl;
    logic [W-1:0] cur_d;
    bit           e_ready, e_shift, e_busy, e_qv, e_pop;
    logic [W-1:0] e_out;
    // Bench copy of the downstream vDFF, fed by the DUT's own outputs.
    logic [W-1:0] obs_out, vd_stall, vd_q;
    logic         obs_shift;
    int           cyc;

    function automatic bit q_equal(input logic [W-1:0] a[$], input logic [W-1:0] b[$]);
        if (a.size() != b.size()) return 1'b0;
        for (int i = 0; i < a.size(); i++) if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        mode = 0; mq.delete(); m_st = 0; m_qv = 0;
        exp_q.delete(); got_q.delete();
        vd_stall = '0; vd_q = '0; cyc = 0;
    endtask

    // Called at a falling edge: drives inputs and computes this cycle's expectations.
    task automatic set_inputs(input bit v, input logic [W-1:0] d, input bit f, input bit fl);
        up.in_valid = v; up.in_data = d; fault_en = f; flush = fl;
        cur_v = v; cur_d = d; cur_f = f; cur_fl = fl;
        e_shift = (mode != 0);
        e_pop   = (mode != 2) && (mq.size() != 0) && !fl;
        e_out   = e_pop ? mq[0] : '0;
        e_ready = (mq.size() < DEPTH) || e_pop;
        e_busy  = (mq.size() != 0) || (mode != 0);
        e_qv    = m_qv;
        #1;
        obs_out = out_data; obs_shift = shift_en;
    endtask

    task automatic tick();
        bit acc;
        acc = cur_v && e_ready && !cur_fl;
        @(posedge clk);
        if (obs_shift) begin vd_q = vd_stall; vd_stall = obs_out; end
        else vd_q = obs_out;
        if (e_shift) begin m_qv = m_st; m_st = e_pop; end
        else begin m_qv = e_pop; m_st = 0; end
        if (e_pop) begin exp_q.push_back(mq[0]); void'(mq.pop_front()); end
        if (cur_fl) mq.delete();
        if (acc) mq.push_back(cur_d);
        if (cur_fl) mode = (mode == 0) ? 0 : 2;
        else case (mode)
            0: mode = cur_f ? 1 : 0;
            1: mode = cur_f ? 1 : 2;
            default: mode = cur_f ? 1 : 0;
        endcase
        cyc++;
        @(negedge clk);
        if (q_valid === 1'b1) got_q.push_back(vd_q);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0; up.in_valid = 1'b0; up.in_data = '0; fault_en = 1'b0; flush = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!(mode == 0 && mq.size() == 0 && n >= 3)) begin
            set_inputs(0, '0, 0, 0);
            tick();
            if (mode == 0 && mq.size() == 0) n++;
            if (cyc > 400) begin
                checks++; fails++;
                $display("FAIL drain_timeout: mode=%0d fifo=%0d required idle", mode, mq.size());
                return;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; up.in_valid = 1'b1; up.in_data = 16'h5A5A; fault_en = 1'b1; flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({up.in_ready, shift_en, busy, q_valid, out_data} !== {4'b1000, 16'h0000}) begin
            fails++;
            $display("FAIL reset_hold: rdy/sh/busy/qv/data=%b%b%b%b/%h required 1000/0000",
                     up.in_ready, shift_en, busy, q_valid, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        set_inputs(0, '0, 0, 0);
        checks++;
        if ({up.in_ready, shift_en, busy, q_valid, out_data} !== {e_ready, e_shift, e_busy, e_qv, e_out}) begin
            fails++;
            $display("FAIL reset_release: rdy/sh/busy/qv/data=%b%b%b%b/%h required %b%b%b%b/%h",
                     up.in_ready, shift_en, busy, q_valid, out_data, e_ready, e_shift, e_busy, e_qv, e_out);
        end
        tick();
    endtask

    task automatic test_pass();
        bit           tv[5] = '{1, 1, 0, 0, 0};
        logic [W-1:0] td[5] = '{16'h0001, 16'h0002, 16'h0, 16'h0, 16'h0};
        logic [W-1:0] want[$];
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            set_inputs(tv[i], td[i], 0, 0);
            checks++;
            if ({up.in_ready, shift_en, busy, q_valid, out_data} !== {e_ready, e_shift, e_busy, e_qv, e_out}) begin
                fails++;
                $display("FAIL pass_cycle%0d: rdy/sh/busy/qv/data=%b%b%b%b/%h required %b%b%b%b/%h", i,
                         up.in_ready, shift_en, busy, q_valid, out_data, e_ready, e_shift, e_busy, e_qv, e_out);
            end
            tick();
        end
        drain();
        want = '{16'h0001, 16'h0002};
        checks++;
        if (!q_equal(got_q, want)) begin
            fails++;
            $display("FAIL pass_qseq: got %0d words %p required %p", got_q.size(), got_q, want);
        end
    endtask

    task automatic test_proxy();
        logic [W-1:0] want[$];
        int t_a1, t_qv;
        t_a1 = -1; t_qv = -1;
        reset_dut();
        for (int i = 0; i < 9; i++) begin
            set_inputs((i >= 1 && i <= 4), W'(16'h00A0 + i), 1, 0);
            if (t_a1 < 0 && out_data === 16'h00A1) t_a1 = cyc;
            if (t_a1 >= 0 && t_qv < 0 && q_valid === 1'b1) t_qv = cyc;
            checks++;
            if ({up.in_ready, shift_en, busy, q_valid, out_data} !== {e_ready, e_shift, e_busy, e_qv, e_out}) begin
                fails++;
                $display("FAIL proxy_cycle%0d: rdy/sh/busy/qv/data=%b%b%b%b/%h required %b%b%b%b/%h", i,
                         up.in_ready, shift_en, busy, q_valid, out_data, e_ready, e_shift, e_busy, e_qv, e_out);
            end
            tick();
        end
        checks++;
        if (t_a1 < 0 || t_qv != t_a1 + 2) begin
            fails++;
            $display("FAIL proxy_latency: A1 at cycle %0d, q_valid at %0d, required 2 cycles apart", t_a1, t_qv);
        end
        drain();
        want = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4};
        checks++;
        if (!q_equal(got_q, want)) begin
            fails++;
            $display("FAIL proxy_qseq: got %p required %p", got_q, want);
        end
    endtask

    task automatic test_exit();
        bit           tv[7] = '{0, 1, 1, 1, 0, 0, 0};
        logic [W-1:0] td[7] = '{16'h0, 16'h00B5, 16'h00B6, 16'h00B7, 16'h0, 16'h0, 16'h0};
        bit           tf[7] = '{1, 1, 1, 1, 0, 0, 0};
        logic [W-1:0] want[$];
        int nflush;
        nflush = 0;
        reset_dut();
        for (int i = 0; i < 7; i++) begin
            set_inputs(tv[i], td[i], tf[i], 0);
            if (i >= 5 && shift_en === 1'b1) nflush++;
            checks++;
            if ({up.in_ready, shift_en, busy, q_valid, out_data} !== {e_ready, e_shift, e_busy, e_qv, e_out}) begin
                fails++;
                $display("FAIL exit_cycle%0d: rdy/sh/busy/qv/data=%b%b%b%b/%h required %b%b%b%b/%h", i,
                         up.in_ready, shift_en, busy, q_valid, out_data, e_ready, e_shift, e_busy, e_qv, e_out);
            end
            tick();
        end
        checks++;
        if (nflush != 1) begin
            fails++;
            $display("FAIL exit_flush_cycles: got %0d shifting cycles after exit, required 1", nflush);
        end
        want = '{16'h00B5, 16'h00B6, 16'h00B7};
        checks++;
        if (!q_equal(got_q, want)) begin
            fail_line: begin
                fails++;
                $display("FAIL exit_qseq: got %p required %p", got_q, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        int blocked;
        blocked = 0;
        reset_dut();
        for (int i = 0; i < 14; i++) begin
            set_inputs(1, W'($urandom), (i % 2) == 0, 0);
            if (up.in_ready === 1'b0) blocked++;
            checks++;
            if ({up.in_ready, shift_en, busy, q_valid, out_data} !== {e_ready, e_shift, e_busy, e_qv, e_out}) begin
                fails++;
                $display("FAIL b2b_cycle%0d: rdy/sh/busy/qv/data=%b%b%b%b/%h required %b%b%b%b/%h", i,
                         up.in_ready, shift_en, busy, q_valid, out_data, e_ready, e_shift, e_busy, e_qv, e_out);
            end
            tick();
        end
        checks++;
        if (blocked == 0) begin
            fails++;
            $display("FAIL b2b_backpressure: in_ready low on %0d cycles, required at least 1", blocked);
        end
        drain();
        checks++;
        if (!q_equal(got_q, exp_q)) begin
            fails++;
            $display("FAIL b2b_qseq: got %p required %p", got_q, exp_q);
        end
    endtask

    task automatic test_flush();
        bit found;
        found = 0;
        reset_dut();
        for (int i = 0; i < 40; i++) begin
            if (mode == 1 && mq.size() == 3) begin found = 1; break; end
            set_inputs(1, W'($urandom), mode != 1, 0);
            tick();
        end
        checks++;
        if (!found) begin
            fails++;
            $display("FAIL flush_setup: buffered=%0d mode=%0d, required 3 in proxy", mq.size(), mode);
        end
        for (int i = 0; i < 3; i++) begin
            set_inputs(i == 0, W'($urandom), 0, i == 0);
            checks++;
            if ({up.in_ready, shift_en, busy, q_valid, out_data} !== {e_ready, e_shift, e_busy, e_qv, e_out}) begin
                fails++;
                $display("FAIL flush_cycle%0d: rdy/sh/busy/qv/data=%b%b%b%b/%h required %b%b%b%b/%h", i,
                         up.in_ready, shift_en, busy, q_valid, out_data, e_ready, e_shift, e_busy, e_qv, e_out);
            end
            if (i == 2) begin
                checks++;
                if (busy !== 1'b0) begin
                    fails++;
                    $display("FAIL flush_busy_after: got %b required 0", busy);
                end
            end
            tick();
        end
        drain();
        checks++;
        if (!q_equal(got_q, exp_q)) begin
            fails++;
            $display("FAIL flush_qseq: got %p required %p", got_q, exp_q);
        end
    endtask

    task automatic test_random();
        bit f;
        f = 0;
        reset_dut();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) f = ~f;
            set_inputs($urandom_range(0, 1) == 1, W'($urandom), f, $urandom_range(0, 15) == 0);
            checks++;
            if ({up.in_ready, shift_en, busy, q_valid, out_data} !== {e_ready, e_shift, e_busy, e_qv, e_out}) begin
                fails++;
                $display("FAIL rand_cycle%0d: rdy/sh/busy/qv/data=%b%b%b%b/%h required %b%b%b%b/%h", i,
                         up.in_ready, shift_en, busy, q_valid, out_data, e_ready, e_shift, e_busy, e_qv, e_out);
            end
            tick();
        end
        drain();
        checks++;
        if (!q_equal(got_q, exp_q)) begin
            fails++;
            $display("FAIL rand_qseq: got %0d words required %0d words", got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_midreset();
        reset_dut();
        for (int i = 0; i < 6; i++) begin
            set_inputs(1, W'($urandom), (i % 2) == 0, 0);
            tick();
        end
        up.in_valid = 1'b0; fault_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({up.in_ready, shift_en, busy, q_valid, out_data} !== {4'b1000, 16'h0000}) begin
            fails++;
            $display("FAIL midreset_async: rdy/sh/busy/qv/data=%b%b%b%b/%h required 1000/0000",
                     up.in_ready, shift_en, busy, q_valid, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        set_inputs(0, '0, 0, 0);
        checks++;
        if ({up.in_ready, shift_en, busy, q_valid, out_data} !== {4'b1000, 16'h0000}) begin
            fails++;
            $display("FAIL midreset_lost: rdy/sh/busy/qv/data=%b%b%b%b/%h required 1000/0000",
                     up.in_ready, shift_en, busy, q_valid, out_data);
        end
        tick();
    endtask

`ifdef PROXY_STATS_EN
    task automatic test_stats();
        reset_dut();
        fault_en = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (stall_cnt !== 16'd9) begin
            fails++;
            $display("FAIL stats_early: got %0d required 9", stall_cnt);
        end
        repeat (70000) @(posedge clk);
        #1;
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            fails++;
            $display("FAIL stats_saturate: got %h required ffff", stall_cnt);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            fails++;
            $display("FAIL stats_hold: got %h required ffff", stall_cnt);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (stall_cnt !== 16'h0000) begin
            fails++;
            $display("FAIL stats_reset: got %h required 0000", stall_cnt);
        end
        fault_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; up.in_valid = 1'b0; up.in_data = '0; fault_en = 1'b0; flush = 1'b0;
        model_reset();
        test_reset();
        test_pass();
        test_proxy();
        test_exit();
        test_back_to_back();
        test_flush();
        test_midreset();
        test_random();
`ifdef PROXY_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/proxy_stream_feeder.md
PROXY_STREAM_FEEDER -- requirements
Module: proxy_stream_feeder

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, data word width; must match the downstream vDFF row.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, input buffer entries, power of two, at least 2.
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: in_valid  in  1 / in_ready  out  1 / in_data  in  WORD_SIZE; upstream word handshake.
REQ-005 SHALL have ports: fault_en  in  1  proxy-mode request / flush  in  1  synchronous buffer clear.
REQ-006 SHALL have ports: out_data  out  WORD_SIZE, drives vDFF D / shift_en  out  1, drives vDFF shift_en.
REQ-007 SHALL have ports: q_valid  out  1, validity of the vDFF Q this cycle / busy  out  1, FIFO non-empty or state not PASS.

Function
REQ-008 SHALL accept a word when in_valid and in_ready are both high at a clock edge; in_ready = FIFO not full; a full FIFO accepts a push only if it pops in the same cycle.
REQ-009 SHALL implement FSM states PASS, PROXY and FLUSH; shift_en = 1 in PROXY and FLUSH, 0 in PASS.
REQ-010 SHALL transition PASS->PROXY when fault_en = 1, PROXY->FLUSH when fault_en = 0, FLUSH->PASS when fault_en = 0, and FLUSH->PROXY when fault_en = 1.
REQ-011 SHALL pop one FIFO word per cycle in PASS and PROXY when the FIFO is non-empty, presenting it on out_data combinationally with an internal cur_valid = 1.
REQ-012 SHALL drive out_data = 0 and cur_valid = 0 (bubble) when the FIFO is empty, and in every FLUSH cycle; FLUSH never pops.
REQ-013 SHALL keep a shadow model of the vDFF with registers tag_stalled and q_valid: if shift_en, q_valid <= tag_stalled and tag_stalled <= cur_valid; otherwise q_valid <= cur_valid and tag_stalled <= 0.
REQ-014 SHALL therefore give words a latency of 1 cycle in PASS and 2 cycles in PROXY from out_data to a valid vDFF Q.
REQ-015 SHALL guarantee exactly one FLUSH cycle on each exit from PROXY, so the word held in the vDFF stall register reaches Q before shift_en drops.
REQ-016 SHALL, on flush = 1, empty the FIFO at that edge; a push in the same cycle is dropped. The FSM goes to FLUSH if it was in PROXY or FLUSH, and stays in PASS otherwise. Shadow tags are not cleared.
REQ-017 SHALL sample fault_en only at clock edges; a one-cycle fault_en pulse yields PROXY for one cycle, then FLUSH for one cycle.

Reset
REQ-018 SHALL, on rst_n low, asynchronously clear: FSM to PASS, FIFO pointers and count to 0, tag_stalled = 0, q_valid = 0.
REQ-019 SHALL hold outputs at in_ready = 1, shift_en = 0, out_data = 0, busy = 0 during reset and after it; buffered words are lost.

Configuration
REQ-020 SHALL, with PROXY_STATS_EN defined, add output stall_cnt (16 bits), counting cycles with shift_en = 1, saturating at 16'hFFFF and cleared only by reset.
REQ-021 SHALL, without PROXY_STATS_EN, have no stall_cnt port and no counter logic.

Structure
REQ-022 SHALL take the FSM state enum (PASS, PROXY, FLUSH) and the stall counter width from a shared package proxy_pkg.
REQ-023 SHALL implement the buffer as the sub-module proxy_fifo (parameters WORD_SIZE and FIFO_DEPTH; push/pop/clear ports; full/empty/count outputs).

Verification
REQ-024 SHALL pass this case: fault_en = 0, push 0x0001, 0x0002 back-to-back -> shift_en = 0; out_data shows 0x0001 then 0x0002; q_valid is high on the 2 cycles after each.
REQ-025 SHALL pass this case: fault_en = 1 from reset, push 0x00A1..0x00A4 -> shift_en = 1; q_valid rises 2 cycles after 0x00A1 appears on out_data; the bench's vDFF Q sequence is A1, A2, A3, A4.
REQ-026 SHALL pass this case: in PROXY with the last word 0x00B7 on out_data, drop fault_en -> exactly 1 FLUSH cycle with out_data = 0; 0x00B7 valid at Q; then shift_en = 0.
REQ-027 SHALL pass this case: fill FIFO with 4 words while out_data is blocked by a FLUSH, with in_valid held -> in_ready = 0; the next push is accepted only on the cycle of the first pop.
REQ-028 SHALL pass this case: assert flush with 3 words buffered in PROXY -> busy stays high through 1 FLUSH cycle and is 0 the cycle after; no buffered word reaches Q.
REQ-029 SHALL pass this case: with PROXY_STATS_EN, hold fault_en = 1 for 70000 cycles -> stall_cnt = 16'hFFFF and holds; pulse rst_n low -> stall_cnt = 0.
